// File: rtl/bin_to_bcd_iter.sv
// Iterative double-dabble binary-to-BCD converter.
// One shared add-3 and shift datapath handles one input bit per clock.
module bin_to_bcd_iter #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_ovf
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [SW-1:0]   scr_q, scr_d, adj;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   bcd_d;
    logic            ovf_out_d;
    logic            valid_d;

    // Per-digit +3 correction; no carry crosses digit boundaries.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            else
                adj[4*i +: 4] = scr_q[4*i +: 4];
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scr_d     = scr_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        bcd_d     = o_bcd;
        ovf_out_d = o_ovf;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    bin_d   = i_bin;
                    scr_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = {adj[SW-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                ovf_d = ovf_q | adj[SW-1];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d     = scr_d;
                    ovf_out_d = ovf_d;
                    valid_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            o_bcd   <= '0;
            o_ovf   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            o_bcd   <= bcd_d;
            o_ovf   <= ovf_out_d;
            o_valid <= valid_d;
        end
    end

    assign o_busy = (state_q == SHIFT);

endmodule

// File: doc/bin_to_bcd_iter.md
Name: bin_to_bcd_iter

Overview:
Parametrised, iterative double-dabble binary-to-BCD converter. It replaces the fixed 14-bit combinational add-3 stage chain with one shared add-3 + shift datapath, swept over all digits, and runs one bit per clock. It sits between binary counters/ALU results and the 7-segment/display drivers. A start/busy/valid handshake is provided, and overflow is flagged when DIGITS cannot hold the input.

Parameters:
BIN_W, 8, width of binary input (>= 2).
DIGITS, 3, number of BCD output digits (>= 1). The result is exact when 10^DIGITS > 2^BIN_W - 1; otherwise overflow detection applies.

Ports:
i_clk  input  1  clock, all state updates on rising edge.
i_rst  input  1  synchronous active-high reset.
i_start  input  1  request a conversion; sampled only while idle.
i_bin  input  BIN_W  unsigned binary operand; sampled on the accepting edge only.
o_busy  output  1  high while a conversion is in progress.
o_valid  output  1  one-cycle pulse; o_bcd/o_ovf are new this cycle.
o_bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]; holds the last result.
o_ovf  output  1  result exceeded DIGITS digits; holds with o_bcd.

Behaviour:
- Reset (i_rst=1 at an edge): state IDLE; o_busy=0, o_valid=0, o_bcd=0, o_ovf=0; internal shift/scratch registers and counter cleared. Reset overrides everything, including mid-conversion; the aborted result is discarded and o_valid is not pulsed.
- States: IDLE, SHIFT.
- IDLE, edge with i_start=1:
  - latch i_bin into the binary shift register;
  - clear the BCD scratch (4*DIGITS bits) and the sticky overflow bit;
  - load the counter with BIN_W;
  - go to SHIFT; o_busy=1 from the next cycle.
- SHIFT, each edge performs one iteration:
  - Every scratch digit >= 5 gets +3 (4-bit, no carry between digits); digits <= 4 pass unchanged.
  - The concatenation {scratch, binary} shifts left by 1. The binary MSB enters scratch bit 0; the bit leaving scratch MSB is ORed into the sticky overflow bit.
  - The counter decrements.
- Last iteration (counter==1 before the edge):
  - the same edge loads o_bcd with the post-shift scratch and o_ovf with the final sticky bit (including this edge's shifted-out bit);
  - o_valid=1, o_busy=0, state to IDLE.
- Latency: i_start sampled at edge E0 gives o_valid high in the cycle after edge E_BIN_W, i.e. BIN_W+1 cycles from the start cycle. Throughput is one conversion per BIN_W+1 cycles.
- o_valid is high exactly one cycle, and 0 at all other times.
- i_start while busy is ignored: no queueing, no effect on the running conversion, i_bin not resampled.
- i_start high in the o_valid cycle is accepted (state is IDLE), so back-to-back conversions are allowed. i_start held high continuously yields a new conversion every BIN_W+1 cycles.
- o_bcd/o_ovf change only on completion edges and reset.
- Overflow: when o_ovf=1, o_bcd holds the low DIGITS decimal digits of the value (value mod 10^DIGITS). With exact sizing o_ovf is always 0.
- Every output digit is 0..9 for all inputs.

Test Plan:
- BIN_W=8, DIGITS=3; reset, i_bin=255, i_start one cycle -> o_busy=1 for 8 cycles; o_valid pulses 9 cycles after start; o_bcd=12'h255, o_ovf=0.
- BIN_W=8, DIGITS=3; sequential inputs 0, 9, 10, 99, 100, 128 -> o_bcd 12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128. Exhaustive 0..255 is checked against a div/mod reference model.
- BIN_W=8, DIGITS=3:
  - start 37, then pulse i_start with i_bin=200 during busy -> single result 12'h037, no second o_valid;
  - i_start held high over two windows -> results back-to-back with o_valid 9 cycles apart.
- BIN_W=8, DIGITS=2: 99 -> 8'h99, o_ovf=0; 100 -> 8'h00, o_ovf=1; 255 -> 8'h55, o_ovf=1.
- Assert i_rst at the 4th SHIFT cycle of converting 200 -> next cycle o_busy=0, o_bcd=0, no o_valid. A fresh start of 42 then gives 12'h042.
- BIN_W=14, DIGITS=5: 9999 -> 20'h09999 with 15-cycle latency; 16383 -> 20'h16383, o_ovf=0.
